// File: rtl/gen_burst_fsm.sv
// Burst generator control FSM: IDLE/CONFI/GEN/DONE sequencing, pattern address and FIFO write strobe.
// Optional build macro GEN_CONT_MODE_EN: burst length 0 means unbounded generation.
module gen_burst_fsm #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enh_conf_i,
    input  logic              en_low_i,
    input  logic [CNT_W-1:0]  burst_len_i,
    input  logic              full_i,
    output logic              clrh_addr_fsm,
    output logic              enh_config_fsm,
    output logic              enh_gen_fsm,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [CNT_W-1:0]  wr_cnt_o,
    output logic              done_o,
    output logic [1:0]        state_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CONFI = 2'd1;
    localparam logic [1:0] S_GEN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    logic [1:0]        state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  wr_cnt, wr_cnt_inc, len_q;
    logic              in_gen, len_zero, burst_done, last_wr, wr_en, enter_gen, clr;

    assign in_gen   = (state == S_GEN);
    assign len_zero = (len_q == '0);
    assign last_wr  = !len_zero && (wr_cnt == len_q - CNT_W'(1));

`ifdef GEN_CONT_MODE_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // Zero length is unbounded; the counter saturates instead of wrapping.
    assign burst_done = !len_zero && (wr_cnt >= len_q);
    assign wr_cnt_inc = (wr_cnt == CNT_MAX) ? wr_cnt : wr_cnt + CNT_W'(1);
`else
    assign burst_done = (wr_cnt >= len_q);
    assign wr_cnt_inc = wr_cnt + CNT_W'(1);
`endif

    assign wr_en = in_gen && !full_i && !burst_done;

    always_comb begin
        state_nxt = state;
        if (enh_conf_i)
            state_nxt = S_CONFI;
        else if (en_low_i)
            state_nxt = S_IDLE;
        else begin
            case (state)
                S_IDLE, S_CONFI: state_nxt = S_GEN;
                S_GEN:           if ((wr_en && last_wr) || burst_done) state_nxt = S_DONE;
                default:         state_nxt = S_DONE;
            endcase
        end
    end

    assign enter_gen = (state_nxt == S_GEN) && !in_gen;
    // Clearing on the way into IDLE/CONFI makes an abandoned burst read back 0 immediately.
    assign clr = (state_nxt == S_IDLE) || (state_nxt == S_CONFI);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            addr   <= '0;
            wr_cnt <= '0;
            len_q  <= '0;
        end else begin
            state <= state_nxt;
            if (enter_gen)
                len_q <= burst_len_i;
            if (clr) begin
                addr   <= '0;
                wr_cnt <= '0;
            end else if (wr_en) begin
                addr   <= (addr == ADDR_LAST) ? '0 : addr + ADDR_W'(1);
                wr_cnt <= wr_cnt_inc;
            end
        end
    end

    assign clrh_addr_fsm  = (state == S_IDLE) || (state == S_CONFI);
    assign enh_config_fsm = (state == S_CONFI);
    assign enh_gen_fsm    = in_gen;
    assign done_o         = (state == S_DONE);
    assign wr_en_o        = wr_en;
    assign addr_o         = addr;
    assign wr_cnt_o       = wr_cnt;
    assign state_o        = state;

endmodule

// File: tb/tb_gen_burst_fsm.sv
// Directed bench for gen_burst_fsm (DEPTH=16, CNT_W=8); honours GEN_CONT_MODE_EN for the zero-length case.
module tb_gen_burst_fsm;

    logic       clk = 1'b0;
    logic       rst, enh_conf_i, en_low_i, full_i;
    logic [7:0] burst_len_i;
    logic       clrh_addr_fsm, enh_config_fsm, enh_gen_fsm, wr_en_o, done_o;
    logic [3:0] addr_o;
    logic [7:0] wr_cnt_o;
    logic [1:0] state_o;

    int n_cmp = 0;
    int n_err = 0;

    gen_burst_fsm dut (
        .clk(clk), .rst(rst), .enh_conf_i(enh_conf_i), .en_low_i(en_low_i),
        .burst_len_i(burst_len_i), .full_i(full_i),
        .clrh_addr_fsm(clrh_addr_fsm), .enh_config_fsm(enh_config_fsm),
        .enh_gen_fsm(enh_gen_fsm), .wr_en_o(wr_en_o), .addr_o(addr_o),
        .wr_cnt_o(wr_cnt_o), .done_o(done_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_confi();
        enh_conf_i = 1'b1;
        tick();
        enh_conf_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en_low_i = 1'b1; enh_conf_i = 1'b0; full_i = 1'b0; burst_len_i = 8'd0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if ({state_o, clrh_addr_fsm, wr_en_o, addr_o, done_o, enh_gen_fsm, enh_config_fsm}
                !== {2'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL reset_idle cyc%0d: state=%0d clr=%0b wr_en=%0b addr=%0d done=%0b, expected state=0 clr=1 others 0",
                         i, state_o, clrh_addr_fsm, wr_en_o, addr_o, done_o);
            end
        end
    endtask

    task automatic test_burst5();
        go_confi();
        n_cmp++;
        if ({state_o, enh_config_fsm, clrh_addr_fsm, addr_o} !== {2'd1, 1'b1, 1'b1, 4'd0}) begin
            n_err++;
            $display("FAIL burst5_confi: state=%0d cfg=%0b clr=%0b addr=%0d, expected 1 1 1 0",
                     state_o, enh_config_fsm, clrh_addr_fsm, addr_o);
        end
        en_low_i = 1'b0; burst_len_i = 8'd5; full_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            burst_len_i = 8'd2;  // changes during GEN must be ignored
            #1;
            n_cmp++;
            if ({state_o, enh_gen_fsm, wr_en_o, addr_o, wr_cnt_o} !== {2'd2, 1'b1, 1'b1, 4'(i), 8'(i)}) begin
                n_err++;
                $display("FAIL burst5_gen%0d: state=%0d gen=%0b wr_en=%0b addr=%0d cnt=%0d, expected 2 1 1 %0d %0d",
                         i, state_o, enh_gen_fsm, wr_en_o, addr_o, wr_cnt_o, i, i);
            end
        end
        tick();
        n_cmp++;
        if ({state_o, done_o, wr_en_o, wr_cnt_o, addr_o} !== {2'd3, 1'b1, 1'b0, 8'd5, 4'd5}) begin
            n_err++;
            $display("FAIL burst5_done: state=%0d done=%0b wr_en=%0b cnt=%0d addr=%0d, expected 3 1 0 5 5",
                     state_o, done_o, wr_en_o, wr_cnt_o, addr_o);
        end
    endtask

    task automatic test_wrap();
        go_confi();
        burst_len_i = 8'd20;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if ({state_o, wr_en_o, addr_o} !== {2'd2, 1'b1, 4'(i % 16)}) begin
                n_err++;
                $display("FAIL wrap_gen%0d: state=%0d wr_en=%0b addr=%0d, expected 2 1 %0d",
                         i, state_o, wr_en_o, addr_o, i % 16);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({state_o, wr_en_o, addr_o, wr_cnt_o} !== {2'd3, 1'b0, 4'd4, 8'd20}) begin
                n_err++;
                $display("FAIL wrap_done%0d: state=%0d wr_en=%0b addr=%0d cnt=%0d, expected 3 0 4 20",
                         i, state_o, wr_en_o, addr_o, wr_cnt_o);
            end
        end
    endtask

    task automatic test_full_stall();
        logic [5:0] fpat;
        int exp_a[6];
        logic [5:0] exp_w;
        int writes;
        fpat   = 6'b000110;
        exp_w  = 6'b111001;
        exp_a  = '{0, 1, 1, 1, 2, 3};
        writes = 0;
        go_confi();
        burst_len_i = 8'd4;
        for (int k = 0; k < 6; k++) begin
            tick();
            full_i = fpat[k];
            #1;
            if (wr_en_o) writes++;
            n_cmp++;
            if ({state_o, wr_en_o, addr_o, wr_cnt_o} !== {2'd2, exp_w[k], 4'(exp_a[k]), 8'(exp_a[k])}) begin
                n_err++;
                $display("FAIL full_gen%0d: state=%0d wr_en=%0b addr=%0d cnt=%0d, expected 2 %0b %0d %0d",
                         k, state_o, wr_en_o, addr_o, wr_cnt_o, exp_w[k], exp_a[k], exp_a[k]);
            end
        end
        tick();
        full_i = 1'b0;
        n_cmp++;
        if ({state_o, wr_cnt_o, addr_o} !== {2'd3, 8'd4, 4'd4} || writes != 4) begin
            n_err++;
            $display("FAIL full_done: state=%0d cnt=%0d addr=%0d writes=%0d, expected 3 4 4 4",
                     state_o, wr_cnt_o, addr_o, writes);
        end
    endtask

    task automatic test_abort_priority();
        go_confi();
        burst_len_i = 8'd8;
        tick(); tick(); tick();
        n_cmp++;
        if ({state_o, wr_cnt_o} !== {2'd2, 8'd2}) begin
            n_err++;
            $display("FAIL abort_pre: state=%0d cnt=%0d, expected 2 2", state_o, wr_cnt_o);
        end
        en_low_i = 1'b1; enh_conf_i = 1'b1;
        tick();
        n_cmp++;
        if ({state_o, addr_o, wr_cnt_o} !== {2'd1, 4'd0, 8'd0}) begin
            n_err++;
            $display("FAIL abort_confi: state=%0d addr=%0d cnt=%0d, expected 1 0 0", state_o, addr_o, wr_cnt_o);
        end
        enh_conf_i = 1'b0;
        tick();
        n_cmp++;
        if ({state_o, clrh_addr_fsm} !== {2'd0, 1'b1}) begin
            n_err++;
            $display("FAIL abort_idle: state=%0d clr=%0b, expected 0 1", state_o, clrh_addr_fsm);
        end
        en_low_i = 1'b0; burst_len_i = 8'd3;
        tick();
        n_cmp++;
        if ({state_o, wr_en_o, addr_o, wr_cnt_o} !== {2'd2, 1'b1, 4'd0, 8'd0}) begin
            n_err++;
            $display("FAIL abort_restart: state=%0d wr_en=%0b addr=%0d cnt=%0d, expected 2 1 0 0",
                     state_o, wr_en_o, addr_o, wr_cnt_o);
        end
        tick();
        en_low_i = 1'b1;
        tick();
        n_cmp++;
        if ({state_o, addr_o, wr_cnt_o} !== {2'd0, 4'd0, 8'd0}) begin
            n_err++;
            $display("FAIL abort_enlow: state=%0d addr=%0d cnt=%0d, expected 0 0 0", state_o, addr_o, wr_cnt_o);
        end
        en_low_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        go_confi();
        burst_len_i = 8'd10;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({state_o, clrh_addr_fsm, wr_en_o, addr_o, wr_cnt_o, done_o} !== {2'd0, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid: state=%0d clr=%0b wr_en=%0b addr=%0d cnt=%0d done=%0b, expected 0 1 0 0 0 0",
                     state_o, clrh_addr_fsm, wr_en_o, addr_o, wr_cnt_o, done_o);
        end
    endtask

    task automatic test_zero_len();
        go_confi();
        burst_len_i = 8'd0;
        tick();
`ifdef GEN_CONT_MODE_EN
        for (int i = 0; i < 120; i++) begin
            n_cmp++;
            if ({state_o, wr_en_o, addr_o} !== {2'd2, 1'b1, 4'(i % 16)}) begin
                n_err++;
                $display("FAIL zero_cont%0d: state=%0d wr_en=%0b addr=%0d, expected 2 1 %0d",
                         i, state_o, wr_en_o, addr_o, i % 16);
            end
            tick();
        end
`else
        n_cmp++;
        if ({state_o, wr_en_o} !== {2'd2, 1'b0}) begin
            n_err++;
            $display("FAIL zero_gen: state=%0d wr_en=%0b, expected 2 0", state_o, wr_en_o);
        end
        tick();
        n_cmp++;
        if ({state_o, done_o, wr_cnt_o, addr_o} !== {2'd3, 1'b1, 8'd0, 4'd0}) begin
            n_err++;
            $display("FAIL zero_done: state=%0d done=%0b cnt=%0d addr=%0d, expected 3 1 0 0",
                     state_o, done_o, wr_cnt_o, addr_o);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_burst5();
        test_wrap();
        test_full_stall();
        test_abort_priority();
        test_reset_mid();
        test_zero_len();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
